// File: rtl/frame_table_ctrl.sv
// frame_table_ctrl: in-order descriptor FIFO over a registered-read RAM with a 2-entry output buffer
module frame_table_ctrl #(
  parameter int DATA_WIDTH = 40,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  overflow,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_q
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   ram_used_q, ram_used_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            out_cnt_q, out_cnt_d, cnt_after;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d, head;
  logic                  overflow_q, overflow_d, in_ready_q, in_ready_d;
  logic [ADDR_WIDTH+1:0] level_q, level_d;
  logic                  clr, push, pop, issue;
  // next-state: push into RAM, read ahead into the buffer, pop the head; reset and flush clear everything
  always_comb begin
    clr = flush | ~rst_n;
    push = in_valid & in_ready_q & ~clr;
    pop = (out_cnt_q != 2'd0) & out_ready & ~clr;
    cnt_after = out_cnt_q - {1'b0, pop};
    issue = ~clr & (ram_used_q != '0) & ((cnt_after + {1'b0, inflight_q}) < 2'd2);
    wr_ptr_d = clr ? '0 : wr_ptr_q + ADDR_WIDTH'(push);
    rd_ptr_d = clr ? '0 : rd_ptr_q + ADDR_WIDTH'(issue);
    ram_used_d = clr ? '0 : ram_used_q + (ADDR_WIDTH + 1)'(push) - (ADDR_WIDTH + 1)'(issue);
    inflight_d = issue;
    out_cnt_d = clr ? 2'd0 : cnt_after + {1'b0, inflight_q};
    head = pop ? buf1_q : buf0_q;
    buf0_d = (inflight_q && cnt_after == 2'd0) ? ram_q : head;
    buf1_d = (inflight_q && cnt_after == 2'd1) ? ram_q : buf1_q;
    overflow_d = ~clr & (overflow_q | (in_valid & ~in_ready_q));
    in_ready_d = ram_used_d < DEPTH_C;
    level_d = (ADDR_WIDTH + 2)'(ram_used_d) + (ADDR_WIDTH + 2)'(inflight_d) + (ADDR_WIDTH + 2)'(out_cnt_d);
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ram_used_q <= '0;
      inflight_q <= 1'b0;
      out_cnt_q <= 2'd0;
      buf0_q <= '0;
      buf1_q <= '0;
      overflow_q <= 1'b0;
      in_ready_q <= 1'b0;
      level_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ram_used_q <= ram_used_d;
      inflight_q <= inflight_d;
      out_cnt_q <= out_cnt_d;
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
      overflow_q <= overflow_d;
      in_ready_q <= in_ready_d;
      level_q <= level_d;
    end
  end
  assign in_ready = in_ready_q;
  assign out_valid = out_cnt_q != 2'd0;
  assign out_data = buf0_q;
  assign level = level_q;
  assign overflow = overflow_q;
  assign ram_we = push;
  assign ram_write_addr = wr_ptr_q;
  assign ram_data = in_data;
  assign ram_read_addr = rd_ptr_q;
endmodule

// File: tb/tb_frame_table_ctrl.sv
// tb_frame_table_ctrl: randomized and directed checks of frame_table_ctrl against a queue-based model
module tb_frame_table_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, overflow, ram_we;
  logic [39:0] in_data = '0, out_data, ram_data, ram_q;
  logic [5:0] level;
  logic [3:0] ram_write_addr, ram_read_addr;
  logic [39:0] mem [16];
  int checks = 0, errors = 0;
  logic [39:0] q [$];
  int cnt_m = 0;
  logic ovf_m = 1'b0, rst_m = 1'b1;
  logic ov_s, ir_s;
  always #5 clk = ~clk;
  frame_table_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .overflow(overflow), .ram_data(ram_data), .ram_write_addr(ram_write_addr),
    .ram_we(ram_we), .ram_read_addr(ram_read_addr), .ram_q(ram_q)
  );
  always @(posedge clk) begin
    ram_q <= mem[ram_read_addr];
    if (ram_we) mem[ram_write_addr] <= ram_data;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic iv, input logic [39:0] d, input logic ordy, input logic fl, input logic rn);
    @(negedge clk);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl; rst_n = rn;
    #1;
    ov_s = out_valid; ir_s = in_ready;
    chk("level", 64'(level), 64'(cnt_m));
    chk("overflow", 64'(overflow), 64'(ovf_m));
    if (rst_m) chk("ready_in_reset", 64'(in_ready), 0);
    else if (cnt_m < 16) chk("ready_room", 64'(in_ready), 1);
    if (cnt_m == 18) chk("ready_full", 64'(in_ready), 0);
    if (fl || !rn) begin
      q.delete(); cnt_m = 0; ovf_m = 1'b0;
    end else begin
      if (iv && !in_ready) ovf_m = 1'b1;
      if (out_valid && ordy) begin
        if (q.size() == 0) chk("pop_empty", 64'(out_data), 64'hdead);
        else begin
          chk("data", 64'(out_data), 64'(q.pop_front()));
          cnt_m--;
        end
      end
      if (iv && in_ready) begin
        q.push_back(d);
        cnt_m++;
      end
    end
    rst_m = ~rn;
    @(posedge clk);
  endtask
  initial begin
    logic seen;
    logic [39:0] x;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rst_we", 64'(ram_we), 0);
    chk("rst_waddr", 64'(ram_write_addr), 0);
    chk("rst_raddr", 64'(ram_read_addr), 0);
    chk("rst_valid", 64'(ov_s), 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("ready_after_rst", 64'(ir_s), 1);
    step(1, 40'h00_1234_5678, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("lat_t1", 64'(ov_s), 0);
    step(0, 0, 0, 0, 1);
    chk("lat_t2", 64'(ov_s), 0);
    step(0, 0, 1, 0, 1);
    chk("lat_t3", 64'(ov_s), 1);
    step(0, 0, 0, 0, 1);
    chk("drained", 64'(ov_s), 0);
    for (int i = 0; i < 20; i++) step(1, 40'h100 + 40'(i), 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("full_level", 64'(level), 18);
    chk("full_ovf", 64'(overflow), 1);
    step(0, 0, 1, 0, 1);
    step(1, 40'h200, 0, 0, 1);
    step(1, 40'h201, 0, 0, 1);
    step(1, 40'h202, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 0, 1);
    chk("full_drain", 64'(q.size()), 0);
    for (int i = 0; i < 20; i++) step(1, 40'h300 + 40'(i), 0, 0, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 1);
    step(1, 40'hab_cdef_0123, 0, 0, 1);
    chk("flush_valid", 64'(ov_s), 0);
    chk("flush_level", 64'(level), 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("flush_lat2", 64'(ov_s), 0);
    step(0, 0, 1, 0, 1);
    chk("flush_lat3", 64'(ov_s), 1);
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step(1, 40'h1000 + 40'(k), 1, 0, 1);
      if (seen) chk("no_gap", 64'(ov_s), 1);
      seen = seen | ov_s;
    end
    for (int i = 0; i < 5; i++) step(1, 40'h2000 + 40'(i), 1, 0, 1);
    step(1, 40'h2100, 1, 0, 0);
    chk("mid_rst_we", 64'(ram_we), 0);
    step(0, 0, 0, 0, 1);
    chk("mid_rst_valid", 64'(ov_s), 0);
    chk("mid_rst_raddr", 64'(ram_read_addr), 0);
    step(0, 0, 0, 0, 1);
    chk("mid_rst_ready", 64'(ir_s), 1);
    for (int k = 0; k < 400; k++) begin
      x = {8'($urandom), $urandom};
      step($urandom_range(0, 9) < 7, x, $urandom_range(0, 9) < ((k / 100) % 2 ? 8 : 3),
           $urandom_range(0, 59) == 0, 1);
    end
    for (int i = 0; i < 40 && q.size() != 0; i++) step(0, 0, 1, 0, 1);
    chk("final_drain", 64'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
